// File: rtl/layer00_row_sched.sv
`default_nettype none
// ============================================================================
// layer00_row_sched : per-layer row sequencer between the layer controller,
// the input parser and downstream; optional watchdog under SCHED_TIMEOUT_EN.
// Revision: 1.0
// ============================================================================
module layer00_row_sched #(
  parameter int ROW_W   = 9,
  parameter int COL_W   = 9,
  parameter int TIMEOUT = 4096
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             iLayerStart,
  input  logic [ROW_W-1:0] iNumRows,
  input  logic [COL_W-1:0] iNumCols,
  input  logic             i_fromYolo,
  input  logic             iDownReady,
  input  logic             iMacVld,
  input  logic             iColEnd,
  output logic             oParseStart,
  output logic             oFromYolo,
  output logic [ROW_W-1:0] oRowIdx,
  output logic [COL_W-1:0] oColCnt,
  output logic             oBusy,
  output logic             oLayerDone,
  output logic             oErr,
  output logic             oTimeout
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_RDY = 3'd1,
    START    = 3'd2,
    RUN      = 3'd3,
    NEXT     = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ROW_W-1:0] rows_q;
  logic [ROW_W-1:0] row_idx;
  logic [COL_W-1:0] cols_q;
  logic [COL_W-1:0] col_cnt;
  logic [COL_W-1:0] col_final;
  logic             from_yolo;
  logic             err;
  logic             start_acc;
  logic             last_row;
  logic             stray;
  logic             timeout_hit;

  if (TIMEOUT < 1) begin : g_timeout_chk
    $error("TIMEOUT must be at least 1");
  end

  assign start_acc = (state == IDLE) && iLayerStart;
  assign last_row  = (row_idx == rows_q - ROW_W'(1));
  assign stray     = (state != RUN) && (iMacVld || iColEnd);
  // A beat arriving with iColEnd is folded in before the length check.
  assign col_final = (iMacVld && !(&col_cnt)) ? col_cnt + COL_W'(1) : col_cnt;

`ifdef SCHED_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  assign timeout_hit = (state == RUN) && !iColEnd && (wd_cnt == WD_W'(TIMEOUT));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state == START) begin
        wd_cnt <= '0;
      end else if ((state == RUN) && !timeout_hit) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end
      if (start_acc) begin
        timeout_q <= 1'b0;
      end else if (timeout_hit) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign oTimeout = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign oTimeout    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (iLayerStart) begin
          state_nxt = (iNumRows == '0) ? DONE : WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (iDownReady) begin
          state_nxt = START;
        end
      end
      START: state_nxt = RUN;
      RUN: begin
        if (iColEnd) begin
          state_nxt = last_row ? DONE : NEXT;
        end else if (timeout_hit) begin
          state_nxt = DONE;
        end
      end
      NEXT:    state_nxt = WAIT_RDY;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rows_q    <= '0;
      cols_q    <= '0;
      from_yolo <= 1'b0;
      row_idx   <= '0;
      col_cnt   <= '0;
      err       <= 1'b0;
    end else if (start_acc) begin
      rows_q    <= iNumRows;
      cols_q    <= iNumCols;
      from_yolo <= i_fromYolo;
      row_idx   <= '0;
      col_cnt   <= '0;
      err       <= 1'b0;
    end else begin
      if (stray || timeout_hit) begin
        err <= 1'b1;
      end
      if (state == RUN) begin
        col_cnt <= col_final;
        if (iColEnd && (col_final != cols_q)) begin
          err <= 1'b1;
        end
      end
      if (state == NEXT) begin
        row_idx <= row_idx + ROW_W'(1);
        col_cnt <= '0;
      end
    end
  end

  assign oParseStart = (state == START);
  assign oLayerDone  = (state == DONE);
  assign oBusy       = (state != IDLE);
  assign oFromYolo   = from_yolo;
  assign oRowIdx     = row_idx;
  assign oColCnt     = col_cnt;
  assign oErr        = err;

endmodule
`default_nettype wire

// File: tb/tb_layer00_row_sched.sv
`default_nettype none
// ============================================================================
// tb_layer00_row_sched : directed + randomized bench for layer00_row_sched,
// compared every cycle against a row-level behavioural model.
// Revision: 1.0
// ============================================================================
module tb_layer00_row_sched;

  localparam int ROW_W = 4;
  localparam int COL_W = 3;
  localparam int TO    = 16;
  localparam int CMAX  = (1 << COL_W) - 1;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             iLayerStart = 1'b0;
  logic [ROW_W-1:0] iNumRows = '0;
  logic [COL_W-1:0] iNumCols = '0;
  logic             i_fromYolo = 1'b0;
  logic             iDownReady = 1'b1;
  logic             iMacVld = 1'b0;
  logic             iColEnd = 1'b0;
  logic             oParseStart, oFromYolo, oBusy, oLayerDone, oErr, oTimeout;
  logic [ROW_W-1:0] oRowIdx;
  logic [COL_W-1:0] oColCnt;

  layer00_row_sched #(.ROW_W(ROW_W), .COL_W(COL_W), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn), .iLayerStart(iLayerStart), .iNumRows(iNumRows),
    .iNumCols(iNumCols), .i_fromYolo(i_fromYolo), .iDownReady(iDownReady),
    .iMacVld(iMacVld), .iColEnd(iColEnd), .oParseStart(oParseStart),
    .oFromYolo(oFromYolo), .oRowIdx(oRowIdx), .oColCnt(oColCnt), .oBusy(oBusy),
    .oLayerDone(oLayerDone), .oErr(oErr), .oTimeout(oTimeout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model: what each output must be in the cycle following each clock edge.
  bit m_busy, m_parse, m_done, m_wait, m_run, m_adv, m_yolo, m_err, m_to;
  int m_rows, m_cols, m_row, m_cnt, m_runlen;

  always @(posedge clk or negedge rstn) begin : model
    bit was_idle, was_wait, was_start, was_run, was_adv;
    if (!rstn) begin
      {m_busy, m_parse, m_done, m_wait, m_run, m_adv, m_yolo, m_err, m_to} = '0;
      m_rows = 0; m_cols = 0; m_row = 0; m_cnt = 0; m_runlen = 0;
    end else begin
      was_idle = !m_busy; was_wait = m_wait; was_start = m_parse;
      was_run = m_run; was_adv = m_adv;
      m_parse = 1'b0; m_done = 1'b0; m_adv = 1'b0;
      if ((iMacVld || iColEnd) && !was_run) m_err = 1'b1;
      if (was_idle) begin
        if (iLayerStart) begin
          m_rows = int'(iNumRows); m_cols = int'(iNumCols); m_yolo = i_fromYolo;
          m_row = 0; m_cnt = 0; m_err = 1'b0; m_to = 1'b0;
          if (m_rows == 0) m_done = 1'b1;
          else m_wait = 1'b1;
        end
      end else if (was_wait) begin
        if (iDownReady) begin m_wait = 1'b0; m_parse = 1'b1; end
      end else if (was_start) begin
        m_run = 1'b1; m_runlen = 0;
      end else if (was_run) begin
        if (iMacVld && m_cnt < CMAX) m_cnt = m_cnt + 1;
        if (iColEnd) begin
          if (m_cnt != m_cols) m_err = 1'b1;
          m_run = 1'b0;
          if (m_row == m_rows - 1) m_done = 1'b1;
          else m_adv = 1'b1;
        end
`ifdef SCHED_TIMEOUT_EN
        else if (m_runlen == TO) begin
          m_to = 1'b1; m_err = 1'b1; m_run = 1'b0; m_done = 1'b1;
        end
`endif
        else m_runlen = m_runlen + 1;
      end else if (was_adv) begin
        m_row = m_row + 1; m_cnt = 0; m_wait = 1'b1;
      end
      m_busy = m_wait | m_parse | m_run | m_adv | m_done;
    end
  end

  int parse_cnt = 0, done_cnt = 0, last_parse = 0, last_done = 0;
  int parse_rows[$];
  int t_start, t_parse0, t_rdy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300 && oBusy; i++) begin @(posedge clk); #1; end
    if (oBusy) chk("wait_idle_bound", 32'd1, 32'd0);
  endtask

  task automatic wait_parse(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (oParseStart) begin ok = 1'b1; break; end
    end
    if (!ok) chk("wait_parse_bound", 32'd0, 32'd1);
  endtask

  task automatic pulse_start(input int rows, input int cols, input bit yolo);
    wait_idle();
    @(negedge clk);
    iLayerStart = 1'b1; iNumRows = ROW_W'(rows); iNumCols = COL_W'(cols); i_fromYolo = yolo;
    t_start = cyc;
    @(negedge clk);
    iLayerStart = 1'b0;
  endtask

  task automatic do_layer(input int rows, input int cols, input int beats, input bit coinc,
                          input int gap, input bit rnd, input bit yolo);
    bit ok;
    int n, g;
    if (rnd && $urandom_range(0, 3) == 0) begin
      wait_idle();
      @(negedge clk); iMacVld = 1'b1;
      @(negedge clk); iMacVld = 1'b0;
    end
    pulse_start(rows, cols, yolo);
    for (int r = 0; r < rows; r++) begin
      wait_parse(ok);
      if (!ok) return;
      if (r == 0) t_parse0 = cyc;
      @(negedge clk); @(negedge clk);
      n = rnd ? (($urandom_range(0, 1) == 1) ? cols : int'($urandom_range(0, 9))) : beats;
      if (rnd) coinc = bit'($urandom_range(0, 1));
      for (int b = 0; b < n; b++) begin
        if (rnd && b < 3 && $urandom_range(0, 3) == 0) @(negedge clk);
        iMacVld = 1'b1; iColEnd = coinc && (b == n - 1);
        @(negedge clk);
        iMacVld = 1'b0; iColEnd = 1'b0;
      end
      g = rnd ? int'($urandom_range(0, 3)) : ((r == 0) ? gap : 0);
      if (g > 0) iDownReady = 1'b0;
      if (!(coinc && n > 0)) begin
        iColEnd = 1'b1;
        @(negedge clk);
        iColEnd = 1'b0;
      end
      if (rnd && $urandom_range(0, 1) == 1) begin
        iLayerStart = 1'b1; iNumRows = ROW_W'($urandom);
        @(negedge clk);
        iLayerStart = 1'b0;
      end
      if (g > 0) begin
        repeat (g) @(negedge clk);
        iDownReady = 1'b1; t_rdy = cyc;
      end
    end
  endtask

  initial begin : stim
    bit ok;
    int p0, d0;
    fork
      forever begin
        @(posedge clk); #1;
        if (rstn) begin
          chk("busy", 32'(oBusy), 32'(m_busy));
          chk("parse_start", 32'(oParseStart), 32'(m_parse));
          chk("layer_done", 32'(oLayerDone), 32'(m_done));
          chk("row_idx", 32'(oRowIdx), 32'(m_row));
          chk("col_cnt", 32'(oColCnt), 32'(m_cnt));
          chk("from_yolo", 32'(oFromYolo), 32'(m_yolo));
          chk("err", 32'(oErr), 32'(m_err));
          chk("timeout", 32'(oTimeout), 32'(m_to));
          if (oParseStart) begin parse_cnt++; last_parse = cyc; parse_rows.push_back(int'(oRowIdx)); end
          if (oLayerDone) begin done_cnt++; last_done = cyc; end
        end
      end
    join_none

    #12;
    chk("rst_outputs", {oParseStart, oFromYolo, oBusy, oLayerDone, oErr, oTimeout}, 32'd0);
    chk("rst_counters", {oRowIdx, oColCnt}, 32'd0);
    @(negedge clk); rstn = 1'b1;

    // Three rows of four beats each, downstream always ready.
    parse_rows.delete(); p0 = parse_cnt; d0 = done_cnt;
    do_layer(3, 4, 4, 1'b0, 0, 1'b0, 1'b1);
    wait_idle();
    chk("l3_parse_pulses", parse_cnt - p0, 3);
    chk("l3_done_pulses", done_cnt - d0, 1);
    chk("l3_err", 32'(oErr), 0);
    chk("l3_yolo_latched", 32'(oFromYolo), 1);
    chk("start_to_parse", t_parse0 - t_start, 2);
    for (int i = 0; i < 3; i++)
      chk($sformatf("row_at_parse%0d", i), (i < parse_rows.size()) ? parse_rows[i] : -1, i);

    // Fourth beat coincident with iColEnd is counted: no error.
    do_layer(2, 4, 4, 1'b1, 0, 1'b0, 1'b0);
    wait_idle();
    chk("coinc_err", 32'(oErr), 0);

    // Short row flags an error but the layer still finishes.
    d0 = done_cnt;
    do_layer(2, 4, 2, 1'b0, 0, 1'b0, 1'b0);
    wait_idle();
    chk("short_err", 32'(oErr), 1);
    chk("short_done", done_cnt - d0, 1);

    // Downstream stalls after row 0; START follows the first ready cycle.
    do_layer(2, 3, 3, 1'b0, 10, 1'b0, 1'b0);
    wait_idle();
    chk("ready_to_parse", last_parse - t_rdy, 1);

    // Column count saturates at all-ones.
    do_layer(1, CMAX, CMAX + 2, 1'b0, 0, 1'b0, 1'b0);
    wait_idle();
    chk("sat_col_cnt", 32'(oColCnt), CMAX);
    chk("sat_err", 32'(oErr), 0);

    // Zero-row layer goes straight to DONE.
    p0 = parse_cnt; d0 = done_cnt;
    pulse_start(0, 2, 1'b0);
    chk("rows0_done_now", 32'(oLayerDone), 1);
    wait_idle();
    chk("rows0_no_parse", parse_cnt - p0, 0);
    chk("rows0_one_done", done_cnt - d0, 1);

    // Stray end-of-row while idle is sticky until the next start.
    @(negedge clk); iColEnd = 1'b1;
    @(negedge clk); iColEnd = 1'b0;
    chk("stray_err", 32'(oErr), 1);
    do_layer(1, 2, 2, 1'b0, 0, 1'b0, 1'b0);
    wait_idle();
    chk("err_cleared", 32'(oErr), 0);

    // Reset in the middle of row 1.
    pulse_start(3, 2, 1'b1);
    wait_parse(ok);
    @(negedge clk); @(negedge clk);
    iMacVld = 1'b1; @(negedge clk); iMacVld = 1'b0;
    iColEnd = 1'b1; @(negedge clk); iColEnd = 1'b0;
    wait_parse(ok);
    @(negedge clk); @(negedge clk);
    iMacVld = 1'b1; @(negedge clk); iMacVld = 1'b0;
    d0 = done_cnt;
    rstn = 1'b0; #1;
    chk("midrst_outputs", {oParseStart, oFromYolo, oBusy, oLayerDone, oErr, oTimeout}, 32'd0);
    chk("midrst_counters", {oRowIdx, oColCnt}, 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("midrst_no_done", done_cnt - d0, 0);
    do_layer(2, 2, 2, 1'b0, 0, 1'b0, 1'b0);
    wait_idle();
    chk("postrst_done", done_cnt - d0, 1);
    chk("postrst_err", 32'(oErr), 0);

`ifdef SCHED_TIMEOUT_EN
    pulse_start(1, 2, 1'b0);
    wait_parse(ok);
    p0 = cyc + 1;
    for (int i = 0; i < 100 && !oLayerDone; i++) begin @(posedge clk); #1; end
    chk("wd_done_latency", cyc - p0, 17);
    chk("wd_timeout", 32'(oTimeout), 1);
    chk("wd_err", 32'(oErr), 1);
    wait_idle();
`else
    pulse_start(1, 2, 1'b0);
    wait_parse(ok);
    repeat (40) @(negedge clk);
    chk("nowd_still_busy", 32'(oBusy), 1);
    chk("nowd_timeout", 32'(oTimeout), 0);
    iColEnd = 1'b1; @(negedge clk); iColEnd = 1'b0;
    wait_idle();
`endif

    for (int k = 0; k < 30; k++) begin
      do_layer(int'($urandom_range(0, 4)), int'($urandom_range(0, CMAX)), 0, 1'b0, 0, 1'b1,
               bit'($urandom_range(0, 1)));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_bound: actual=expired required=finished");
    $fatal(1, "time bound expired");
  end

endmodule
`default_nettype wire
